// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding
// and the per-transfer mode bundle latched at accept.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } mode_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI serial clock divider; sclk is a registered data
// output with one-cycle strobes on the clk edge where it toggles.
module spi_sclk_gen #(
   parameter int CLK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic cpol,
   output logic sclk,
   output logic lead_edge,
   output logic trail_edge
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;
   logic          phase;
   logic          tick;

   assign tick       = en && (div == DIV_LAST);
   assign lead_edge  = tick && !phase;
   assign trail_edge = tick && phase;

   // Count half-periods while enabled; park sclk at cpol otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         div   <= '0;
         phase <= 1'b0;
         sclk  <= 1'b0;
      end else if (!en) begin
         div   <= '0;
         phase <= 1'b0;
         sclk  <= cpol;
      end else begin
         div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            phase <= ~phase;
            sclk  <= ~sclk;
         end
      end
   end

endmodule

// File: rtl/spi_master_gen.sv
// Single-word SPI master with per-transfer mode, chip-select
// decode and a CLK_DIV-wide setup/hold guard around each word.
module spi_master_gen
   import spi_pkg::*;
#(
   parameter int DATA_W  = 12,
   parameter int CLK_DIV = 10,
   parameter int NUM_CS  = 2,
   localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic [CSW-1:0]    cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic [NUM_CS-1:0] cs_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dout
);

   localparam int CNT_W = $clog2(2 * DATA_W * CLK_DIV);
   localparam int BW    = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] XFER_LAST  =
      CNT_W'(2 * DATA_W * CLK_DIV - 1);
   localparam logic [BW-1:0]    BIT_LAST   = BW'(DATA_W - 1);
   localparam logic [CSW:0]     NCS        = NUM_CS[CSW:0];

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt;
   logic               phase_end;
   logic               accept;

   mode_t              mode_q;
   mode_t              mode_in;
   logic [CSW-1:0]     sel_q;
   logic [CSW-1:0]     sel_in;
   logic               cpol_nx;

   logic [DATA_W-1:0]  tx;
   logic [DATA_W-1:0]  rx;
   logic [BW-1:0]      bit_cnt;

   logic               xfer_en;
   logic               lead;
   logic               trail;
   logic               do_sample;
   logic               do_shift;

   function automatic logic first_bit(
      input logic [DATA_W-1:0] v,
      input logic              lsb
   );
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(
      input logic [DATA_W-1:0] v,
      input logic              lsb
   );
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(
      input logic [DATA_W-1:0] v,
      input logic              b,
      input logic              lsb
   );
      return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
   endfunction

   assign accept  = (state_q == IDLE) && start;
   assign mode_in = '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
   assign sel_in  = ({1'b0, cs_sel} < NCS) ? cs_sel : '0;
   assign cpol_nx = accept ? cpol : mode_q.cpol;
   assign xfer_en = (state_q == XFER);
   assign busy    = (state_q != IDLE);

   // Leading edge samples in mode cpha=0; trailing edge in cpha=1.
   assign do_sample = xfer_en && (mode_q.cpha ? trail : lead);
   assign do_shift  = xfer_en &&
      (mode_q.cpha ? lead : (trail && (bit_cnt != BIT_LAST)));

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .clk        (clk),
      .rst        (rst),
      .en         (xfer_en),
      .cpol       (cpol_nx),
      .sclk       (sclk),
      .lead_edge  (lead),
      .trail_edge (trail)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: each busy phase ends when its counter hits the limit.
   always_comb begin
      state_d   = state_q;
      phase_end = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = SETUP;
         end
         SETUP: begin
            phase_end = (cnt == GUARD_LAST);
            if (phase_end) state_d = XFER;
         end
         XFER: begin
            phase_end = (cnt == XFER_LAST);
            if (phase_end) state_d = HOLD;
         end
         HOLD: begin
            phase_end = (cnt == GUARD_LAST);
            if (phase_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Phase cycle counter, restarted at every state change.
   always_ff @(posedge clk) begin
      if (rst || phase_end || state_q == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
   end

   // Chip-select decode: only the latched target goes low while busy.
   always_comb begin
      cs_n = '1;
      if (busy) cs_n[sel_q] = 1'b0;
   end

   // Shift datapath, mode latch and completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= '0;
         sel_q   <= '0;
         tx      <= '0;
         rx      <= '0;
         bit_cnt <= '0;
         mosi    <= 1'b0;
         dout    <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            mode_q  <= mode_in;
            sel_q   <= sel_in;
            rx      <= '0;
            bit_cnt <= '0;
            if (cpha) begin
               tx <= din;
            end else begin
               mosi <= first_bit(din, lsb_first);
               tx   <= shift_out(din, lsb_first);
            end
         end else if (xfer_en) begin
            if (do_sample)
               rx <= shift_in(rx, miso, mode_q.lsb_first);
            if (do_shift) begin
               mosi <= first_bit(tx, mode_q.lsb_first);
               tx   <= shift_out(tx, mode_q.lsb_first);
            end
            if (trail) bit_cnt <= bit_cnt + 1'b1;
         end else if (state_q == HOLD && phase_end) begin
            mosi <= 1'b0;
            dout <= rx;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: doc/spi_master_gen.md
SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning bits per transfer (range 4..32).
REQ-002 SHALL have parameter CLK_DIV, default 10, meaning clk cycles per sclk half-period (minimum 2).
REQ-003 SHALL have parameter NUM_CS, default 2, meaning number of chip-select lines (range 1..8).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on posedge clk only.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, transfer request.
REQ-007 SHALL have port din, input, DATA_W, transmit word.
REQ-008 SHALL have port cs_sel, input, CSW = max(1, clog2(NUM_CS)), target slave index.
REQ-009 SHALL have ports cpol, cpha, lsb_first, input, 1 each, per-transfer mode.
REQ-010 SHALL have port miso, input, 1, slave data in.
REQ-011 SHALL have port sclk, output, 1, serial clock.
REQ-012 SHALL have port mosi, output, 1, master data out.
REQ-013 SHALL have port cs_n, output, NUM_CS, active-low chip selects.
REQ-014 SHALL have port busy, output, 1, transfer in progress.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port dout, output, DATA_W, received word.

Function
REQ-017 SHALL accept start only when state is IDLE (busy=0), latching din, cs_sel, cpol, cpha, lsb_first on the accept edge T0.
REQ-018 SHALL ignore start while busy=1, with no effect on the transfer in progress or latched values.
REQ-019 SHALL use states IDLE->SETUP->XFER->HOLD->IDLE, where SETUP and HOLD each last CLK_DIV cycles and XFER lasts 2*DATA_W*CLK_DIV cycles.
REQ-020 SHALL drive busy=1 from T0+1 until HOLD exits, and drive cs_n[sel]=0 over the same interval, with all other cs_n bits held at 1.
REQ-021 SHALL hold sclk at latched cpol outside XFER and toggle it every CLK_DIV cycles in XFER, giving exactly DATA_W full periods.
REQ-022 SHALL, with cpha=0, place the first bit on mosi at SETUP entry, sample miso on each leading sclk edge, and shift mosi on each trailing edge except the last.
REQ-023 SHALL, with cpha=1, shift mosi on each leading edge (first bit on the first leading edge) and sample miso on each trailing edge.
REQ-024 SHALL transmit din[DATA_W-1] first when lsb_first=0 and din[0] first when lsb_first=1, and assemble dout in the same bit order.
REQ-025 SHALL, on HOLD exit, deassert all cs_n, set busy=0, update dout, and pulse done=1 for exactly one cycle at T0+1+(2*DATA_W+2)*CLK_DIV.
REQ-026 SHALL hold dout stable between done pulses.
REQ-027 SHALL accept a start asserted during the done cycle, so cs_n is high for exactly one cycle between back-to-back transfers.
REQ-028 SHALL hold mosi at 0 in IDLE.
REQ-029 SHALL treat cs_sel >= NUM_CS as index 0.

Reset
REQ-030 SHALL, when rst=1 at a clk edge, force state=IDLE, sclk=0, mosi=0, cs_n=all ones, busy=0, done=0, dout=0, and clear all counters, including mid-transfer.
REQ-031 SHALL let rst take priority over start in the same cycle.
REQ-032 SHALL hold sclk=0 after reset until the first accepted transfer latches cpol.

Structure
REQ-033 SHALL place the state enum (IDLE, SETUP, XFER, HOLD) and a packed mode struct {cpol, cpha, lsb_first} in shared package spi_pkg.
REQ-034 SHALL implement the sclk divider/edge generator as sub-module spi_sclk_gen, which emits one-cycle lead_edge/trail_edge strobes and the sclk level from an enable and cpol.
REQ-035 SHALL generate no derived clocks; sclk is a registered data output.

Verification
REQ-036 SHALL cover mode 0, MSB-first, DATA_W=12, CLK_DIV=10, din=12'hA5C, miso looped to mosi -> mosi sequence 1010_0101_1100, dout=12'hA5C, done at T0+261.
REQ-037 SHALL cover cpol=1, cpha=1, lsb_first=1, din=12'h001, miso tied 1 -> sclk idles high, first mosi bit 1 on first falling edge, dout=12'hFFF.
REQ-038 SHALL cover start pulsed again 50 cycles after T0 with din=12'hFFF -> ignored, original word transmitted, exactly one done pulse.
REQ-039 SHALL cover rst asserted 100 cycles into a transfer -> next cycle cs_n=2'b11, busy=0, sclk=0, dout=0, no done pulse.
REQ-040 SHALL cover cs_sel=1 with start held high across done -> cs_n[1] low, one cycle high between transfers, cs_n[0] never low.
REQ-041 SHALL cover cs_sel=3 with NUM_CS=2 -> cs_n[0] selected.
